// File: rtl/mont_precomp.sv
// mont_precomp: iterative n' = -n^-1 mod 2^LEN and 2^(2*LEN) mod n.
// Add/shift/subtract only; results held until the next run completes.
module mont_precomp #(
    parameter int LEN = 2048
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           start,
    input  logic [LEN-1:0] n,
    output logic           busy,
    output logic           done,
    output logic           err,
    output logic [LEN-1:0] n_prime,
    output logic [LEN-1:0] r2_mod_n
);

    localparam int CW = $clog2(2 * LEN) + 1;
    localparam int IW = $clog2(LEN);
    localparam logic [CW-1:0] LEN_C  = CW'(LEN);
    localparam logic [CW-1:0] LAST_C = CW'(2 * LEN - 1);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        FIN
    } state_t;

    state_t         state, state_d;
    logic [LEN-1:0] nr, nr_d;
    logic [LEN-1:0] s, s_d;
    logic [LEN-1:0] x, x_d;
    logic [LEN:0]   r, r_d;
    logic [CW-1:0]  cnt, cnt_d;
    logic           busy_d, done_d, err_d;
    logic [LEN-1:0] np_d, r2_d;

    logic [IW-1:0]  idx;
    logic [LEN:0]   t;
    logic [LEN:0]   r_step;
    logic [LEN-1:0] s_add;
    logic           n_ok;

    assign idx    = cnt[IW-1:0];
    assign t      = {r[LEN-1:0], 1'b0};
    assign r_step = (t >= {1'b0, nr}) ? t - {1'b0, nr} : t;
    assign s_add  = s + (nr << idx);
    // odd and not 1 is the same as odd and >= 3
    assign n_ok   = n[0] && (n[LEN-1:1] != '0);

    always_comb begin
        state_d = state;
        nr_d    = nr;
        s_d     = s;
        x_d     = x;
        r_d     = r;
        cnt_d   = cnt;
        busy_d  = busy;
        done_d  = 1'b0;
        err_d   = err;
        np_d    = n_prime;
        r2_d    = r2_mod_n;
        unique case (state)
            IDLE: begin
                if (start) begin
                    if (n_ok) begin
                        state_d = RUN;
                        nr_d    = n;
                        s_d     = '0;
                        x_d     = '0;
                        r_d     = (LEN + 1)'(1);
                        cnt_d   = '0;
                        busy_d  = 1'b1;
                        err_d   = 1'b0;
                    end else begin
                        done_d = 1'b1;
                        err_d  = 1'b1;
                    end
                end
            end
            RUN: begin
                r_d = r_step;
                if (cnt < LEN_C && !s[idx]) begin
                    x_d[idx] = 1'b1;
                    s_d      = s_add;
                end
                if (cnt == LAST_C) begin
                    state_d = FIN;
                    np_d    = x_d;
                    r2_d    = r_step[LEN-1:0];
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                end else begin
                    cnt_d = cnt + CW'(1);
                end
            end
            FIN: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            nr       <= '0;
            s        <= '0;
            x        <= '0;
            r        <= (LEN + 1)'(1);
            cnt      <= '0;
            busy     <= 1'b0;
            done     <= 1'b0;
            err      <= 1'b0;
            n_prime  <= '0;
            r2_mod_n <= '0;
        end else begin
            state    <= state_d;
            nr       <= nr_d;
            s        <= s_d;
            x        <= x_d;
            r        <= r_d;
            cnt      <= cnt_d;
            busy     <= busy_d;
            done     <= done_d;
            err      <= err_d;
            n_prime  <= np_d;
            r2_mod_n <= r2_d;
        end
    end

endmodule

// File: tb/tb_mont_precomp.sv
// tb_mont_precomp: scoreboard bench for mont_precomp at LEN=8 and LEN=64.
// Expected results are queued at stimulus time and popped on done.
module tb_mont_precomp;

    typedef struct {
        logic [63:0] np;
        logic [63:0] r2;
        logic        err;
        int          due;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        start8, start64;
    logic [7:0]  n8;
    logic [63:0] n64;
    logic        busy8, done8, err8;
    logic [7:0]  np8, r28;
    logic        busy64, done64, err64;
    logic [63:0] np64, r264;

    int   checks = 0;
    int   failures = 0;
    int   cyc = 0;
    exp_t q8[$];
    exp_t q64[$];
    exp_t e8, e64;

    mont_precomp #(.LEN(8)) u_d8 (
        .clk(clk), .rst(rst), .start(start8), .n(n8),
        .busy(busy8), .done(done8), .err(err8),
        .n_prime(np8), .r2_mod_n(r28)
    );

    mont_precomp #(.LEN(64)) u_d64 (
        .clk(clk), .rst(rst), .start(start64), .n(n64),
        .busy(busy64), .done(done64), .err(err64),
        .n_prime(np64), .r2_mod_n(r264)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [63:0] got,
                         input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    always begin
        @(posedge clk);
        #1;
        if (done8) begin
            if (q8.size() == 0) check("done8_spurious", 64'd1, 64'd0);
            else begin
                e8 = q8.pop_front();
                check("np8", {56'd0, np8}, e8.np);
                check("r2_8", {56'd0, r28}, e8.r2);
                check("err8", {63'd0, err8}, {63'd0, e8.err});
                check("lat8", 64'(cyc), 64'(e8.due));
            end
        end else if (q8.size() != 0 && cyc > q8[0].due) begin
            check("timeout8", 64'(cyc), 64'(q8[0].due));
            void'(q8.pop_front());
        end
    end

    always begin
        @(posedge clk);
        #1;
        if (done64) begin
            if (q64.size() == 0) check("done64_spurious", 64'd1, 64'd0);
            else begin
                e64 = q64.pop_front();
                check("np64", np64, e64.np);
                check("r2_64", r264, e64.r2);
                check("err64", {63'd0, err64}, {63'd0, e64.err});
                check("lat64", 64'(cyc), 64'(e64.due));
            end
        end else if (q64.size() != 0 && cyc > q64[0].due) begin
            check("timeout64", 64'(cyc), 64'(q64[0].due));
            void'(q64.pop_front());
        end
    end

    task automatic run8(input logic [7:0] nv, input logic [7:0] enp,
                        input logic [7:0] er2, input logic eerr);
        exp_t e;
        e.np  = {56'd0, enp};
        e.r2  = {56'd0, er2};
        e.err = eerr;
        e.due = cyc + 1 + (eerr ? 0 : 16);
        q8.push_back(e);
        n8     = nv;
        start8 = 1'b1;
        tick();
        start8 = 1'b0;
    endtask

    task automatic wait_done8();
        int i = 0;
        while (!done8 && i < 100) begin
            tick();
            i++;
        end
        if (!done8) check("wait_done8", 64'd0, 64'd1);
        tick();
        check("done8_clear", {63'd0, done8}, 64'd0);
    endtask

    task automatic wait_done64();
        int i = 0;
        while (!done64 && i < 300) begin
            tick();
            i++;
        end
        if (!done64) check("wait_done64", 64'd0, 64'd1);
        tick();
    endtask

    task automatic model64(input logic [63:0] nv, output logic [63:0] np,
                           output logic [63:0] r2);
        logic [63:0]  xi;
        logic [128:0] p;
        logic [128:0] m;
        xi = nv;
        repeat (6) xi = xi * (64'd2 - nv * xi);
        np = -xi;
        p  = 129'd1 << 128;
        m  = p % {65'd0, nv};
        r2 = m[63:0];
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog checks=%0d", checks);
        $fatal(1);
    end

    initial begin
        int bc;
        logic [63:0] nv, enp, er2;
        exp_t e;
        rst     = 1'b1;
        start8  = 1'b0;
        start64 = 1'b0;
        n8      = '0;
        n64     = '0;
        tick();
        tick();
        check("rst_busy", {63'd0, busy8}, 64'd0);
        check("rst_done", {63'd0, done8}, 64'd0);
        check("rst_err", {63'd0, err8}, 64'd0);
        check("rst_np", {56'd0, np8}, 64'd0);
        check("rst_r2", {56'd0, r28}, 64'd0);
        check("rst_busy64", {63'd0, busy64}, 64'd0);
        rst = 1'b0;
        tick();

        run8(8'hB5, 8'h63, 8'h0E, 1'b0);
        check("b5_busy", {63'd0, busy8}, 64'd1);
        check("b5_err", {63'd0, err8}, 64'd0);
        bc = 1;
        for (int i = 0; i < 100; i++) begin
            tick();
            if (!busy8) break;
            bc++;
        end
        check("b5_busy_len", 64'(bc), 64'd16);
        check("b5_done", {63'd0, done8}, 64'd1);
        tick();
        check("b5_done_clr", {63'd0, done8}, 64'd0);

        run8(8'hFF, 8'h01, 8'h01, 1'b0);
        wait_done8();
        run8(8'h03, 8'h55, 8'h01, 1'b0);
        repeat (5) tick();
        check("hold_np", {56'd0, np8}, 64'h01);
        check("hold_r2", {56'd0, r28}, 64'h01);
        wait_done8();

        run8(8'h80, 8'h55, 8'h01, 1'b1);
        check("rej80_busy", {63'd0, busy8}, 64'd0);
        check("rej80_done", {63'd0, done8}, 64'd1);
        check("rej80_err", {63'd0, err8}, 64'd1);
        tick();
        check("rej80_dclr", {63'd0, done8}, 64'd0);
        check("rej80_hold", {63'd0, err8}, 64'd1);
        run8(8'h01, 8'h55, 8'h01, 1'b1);
        check("rej01_busy", {63'd0, busy8}, 64'd0);
        check("rej01_err", {63'd0, err8}, 64'd1);
        tick();
        run8(8'hB5, 8'h63, 8'h0E, 1'b0);
        check("err_clear", {63'd0, err8}, 64'd0);
        wait_done8();

        run8(8'hB5, 8'h63, 8'h0E, 1'b0);
        repeat (4) tick();
        n8     = 8'h03;
        start8 = 1'b1;
        tick();
        start8 = 1'b0;
        wait_done8();

        run8(8'hB5, 8'h63, 8'h0E, 1'b0);
        repeat (6) tick();
        rst = 1'b1;
        q8.delete();
        #1;
        check("abort_busy", {63'd0, busy8}, 64'd0);
        check("abort_done", {63'd0, done8}, 64'd0);
        check("abort_np", {56'd0, np8}, 64'd0);
        check("abort_r2", {56'd0, r28}, 64'd0);
        tick();
        rst = 1'b0;
        tick();
        run8(8'hB5, 8'h63, 8'h0E, 1'b0);
        wait_done8();

        for (int k = 0; k < 200; k++) begin
            case (k)
                0: nv = 64'd3;
                1: nv = 64'hFFFF_FFFF_FFFF_FFFF;
                2: nv = 64'h8000_0000_0000_0001;
                default: nv = {$urandom(), $urandom()} | 64'd1;
            endcase
            if (nv < 64'd3) nv = 64'd3;
            model64(nv, enp, er2);
            e.np  = enp;
            e.r2  = er2;
            e.err = 1'b0;
            e.due = cyc + 1 + 128;
            q64.push_back(e);
            n64     = nv;
            start64 = 1'b1;
            tick();
            start64 = 1'b0;
            wait_done64();
            if (k < 20) check("np64_prop", nv * np64, 64'hFFFF_FFFF_FFFF_FFFF);
        end

        repeat (5) tick();
        check("q8_empty", 64'(q8.size()), 64'd0);
        check("q64_empty", 64'(q64.size()), 64'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
